cache_mem_bridge: RTL
=====================

# cache_mem_bridge

Sequential line-transfer engine between the cache controller and the word-wide memory array. It accepts one miss/eviction request per transaction: a 4-word line with per-word dirty mask and victim address, plus an optional fill address. It writes back only the dirty victim words, then optionally fetches the 4-word fill line, one word per memory handshake beat. It returns the assembled 128-bit line to the cache and holds `isLock` high while busy.

## Interface

Parameters:
- `ADDR_WIDTH`, 10: byte address width. Line = 16 bytes, so the line address is `address[ADDR_WIDTH-1:4]`.
- `WORD_WIDTH`, 32: memory word width. Line = 4 words, fixed.

Ports:
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-high.
- `reqValid` input, 1: cache presents a request.
- `reqReady` output, 1: bridge can accept; high only in IDLE with `reset` low.
- `reqIsRead` input, 1: 1 = fill line at `reqAddress` after any writeback.
- `reqAddress` input, ADDR_WIDTH: fill address; bits [3:0] ignored.
- `reqWbAddress` input, ADDR_WIDTH: victim line address; bits [3:0] ignored.
- `reqDirty` input, 4: per-word dirty mask of the victim; bit i = word i.
- `reqWriteData` input, 4*WORD_WIDTH: victim line; word i = bits [32i+31:32i].
- `respValid` output, 1: one-cycle completion pulse.
- `respData` output, 4*WORD_WIDTH: registered fill line; held until the next fill completes.
- `isLock` output, 1: high whenever state is not IDLE.
- `memReq` output, 1: beat request to memory.
- `memWe` output, 1: 1 = write beat, 0 = read beat.
- `memAddress` output, ADDR_WIDTH: word-aligned, `{lineAddr, wordIdx[1:0], 2'b00}`.
- `memWriteData` output, WORD_WIDTH: write word.
- `memReadData` input, WORD_WIDTH: read word, valid in the cycle `memAck` is high.
- `memAck` input, 1: beat completes in any cycle where `memReq && memAck`.

## Operation

- States:
  - IDLE: `reqReady` = 1.
  - WB: writeback beats.
  - FILL: read beats.
  - RESP: `respValid` = 1 for exactly one cycle, then IDLE.
- Accept on a rising edge with `reqValid && reqReady`. On accept, capture all `req*` inputs into internal registers. Later changes on `req*` have no effect.
- Next state after accept:
  - `reqDirty != 0` → WB, starting at the lowest set dirty bit.
  - `reqDirty == 0`, `reqIsRead` = 1 → FILL, word 0.
  - `reqDirty == 0`, `reqIsRead` = 0 → RESP; no memory beats.
- WB:
  - `memWe` = 1, `memAddress` = victim line plus current word index, `memWriteData` = the captured word.
  - Visit words in ascending index order; skip clean words with no beat and no idle cycle.
  - After the last dirty beat: go to FILL (word 0) if `reqIsRead`, else RESP.
- FILL:
  - `memWe` = 0; words 0,1,2,3 in order.
  - On each completed beat, write `memReadData` into an internal line buffer at word i.
  - After the word-3 beat, load `respData` from the buffer (word 3 taken directly from `memReadData`) and go to RESP.
- `respData` updates only on a fill completion. A writeback-only transaction leaves it unchanged.
- `memReq` is high in every WB/FILL cycle and low in IDLE/RESP. If `memAck` is low, the beat stalls: address, data and `memWe` stay stable.

## Timing

- Reset values:
  - state = IDLE
  - `memReq` = 0, `memWe` = 0
  - `memAddress` = 0, `memWriteData` = 0
  - `respValid` = 0, `respData` = 0
  - `isLock` = 0
  - `reqReady` = 0 while `reset` is high.
- All memory-side outputs are registered or derived from registered state and word index. They do not depend on the same-cycle `memAck`.
- With `memAck` tied high, each beat takes 1 cycle. Latency from the accept edge to the `respValid` cycle:
  - RESP-only: 1 cycle.
  - Fill only: 5 cycles.
  - d dirty words, no fill: d+1 cycles.
  - d dirty words plus fill: d+5 cycles.
- No back-to-back accept: `reqReady` is low in RESP. The earliest next accept is the edge after RESP, i.e. the IDLE cycle.
- Reset mid-transaction: abort immediately to IDLE with no `respValid`. Memory words already written stay written. `respData` clears to 0.

## Test plan

- Fill only: `reqIsRead` = 1, `reqDirty` = 0, `reqAddress` = 0x120, `memAck` = 1, memory words 0xA0..0xA3 → read beats at 0x120, 0x124, 0x128, 0x12C; `respValid` 5 cycles after accept; `respData` = {0xA3,0xA2,0xA1,0xA0}.
- Sparse writeback + fill: `reqDirty` = 4'b1010, `reqWbAddress` = 0x3F0, fill at 0x040 → write beats only at 0x3F4 and 0x3FC with the matching words, then 4 read beats; `respValid` 7 cycles after accept.
- Writeback only, all dirty: `reqDirty` = 4'hF, `reqIsRead` = 0 → 4 write beats; `respValid` after 5 cycles; `respData` unchanged from the previous fill.
- Stalled memory: `memAck` low for 3 cycles on each beat of a fill → `memReq`/`memAddress` stable during each stall; `respValid` 17 cycles after accept; `reqValid` held high throughout is not re-accepted.
- Null request: `reqDirty` = 0, `reqIsRead` = 0 → no `memReq`; `respValid` the cycle after accept; `isLock` high for exactly 1 cycle.
- Reset during the WB beat for word 1 of 4 → all outputs at reset values asynchronously; no `respValid`; next request accepted normally after `reset` deasserts.

Source files
------------

// File: rtl/cache_mem_bridge.sv
// Line-transfer engine: writes back the dirty words of a victim line, then
// optionally fetches a 4-word fill line, one memory beat per word.
module cache_mem_bridge #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqIsRead,
  input  logic [ADDR_WIDTH-1:0]   reqAddress,
  input  logic [ADDR_WIDTH-1:0]   reqWbAddress,
  input  logic [3:0]              reqDirty,
  input  logic [4*WORD_WIDTH-1:0] reqWriteData,
  output logic                    respValid,
  output logic [4*WORD_WIDTH-1:0] respData,
  output logic                    isLock,
  output logic                    memReq,
  output logic                    memWe,
  output logic [ADDR_WIDTH-1:0]   memAddress,
  output logic [WORD_WIDTH-1:0]   memWriteData,
  input  logic [WORD_WIDTH-1:0]   memReadData,
  input  logic                    memAck
);

  localparam int LINE_W = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic                    is_read_q, is_read_d;
  logic [3:0]              dirty_q, dirty_d;
  logic [LINE_W-1:0]       fill_line_q, fill_line_d;
  logic [LINE_W-1:0]       wb_line_q, wb_line_d;
  logic [4*WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0][WORD_WIDTH-1:0] buf_q;
  logic [4*WORD_WIDTH-1:0] resp_data_q;
  logic                    resp_valid_q;
  logic                    mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    accept_s;
  logic [2:0]              nxt_s;
  logic [LINE_W-1:0]       line_sel_s;

  // Lowest set mask bit at or above 'from'; result is {found, index}.
  function automatic logic [2:0] first_dirty(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (!r[2] && mask[i] && (3'(i) >= from)) begin
        r = {1'b1, 2'(i)};
      end
    end
    return r;
  endfunction

  assign reqReady     = (state_q == S_IDLE) && !reset;
  assign isLock       = (state_q != S_IDLE);
  assign respValid    = resp_valid_q;
  assign respData     = resp_data_q;
  assign memReq       = mem_req_q;
  assign memWe        = mem_we_q;
  assign memAddress   = mem_addr_q;
  assign memWriteData = mem_wdata_q;

  // Next-state, request capture and next memory-beat outputs.
  always_comb begin
    accept_s    = (state_q == S_IDLE) && reqValid;
    is_read_d   = accept_s ? reqIsRead : is_read_q;
    dirty_d     = accept_s ? reqDirty : dirty_q;
    fill_line_d = accept_s ? reqAddress[ADDR_WIDTH-1:4] : fill_line_q;
    wb_line_d   = accept_s ? reqWbAddress[ADDR_WIDTH-1:4] : wb_line_q;
    wdata_d     = accept_s ? reqWriteData : wdata_q;
    state_d     = state_q;
    idx_d       = idx_q;
    nxt_s       = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          nxt_s = first_dirty(reqDirty, 3'd0);
          if (nxt_s[2]) begin
            state_d = S_WB;
            idx_d   = nxt_s[1:0];
          end else if (reqIsRead) begin
            state_d = S_FILL;
            idx_d   = 2'd0;
          end else begin
            state_d = S_RESP;
            idx_d   = 2'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        if (memAck) begin
          nxt_s = first_dirty(dirty_q, {1'b0, idx_q} + 3'd1);
          if (nxt_s[2]) begin
            idx_d = nxt_s[1:0];
          end else if (is_read_q) begin
            state_d = S_FILL;
            idx_d   = 2'd0;
          end else begin
            state_d = S_RESP;
            idx_d   = 2'd0;
          end
        end else begin
          state_d = S_WB;
        end
      end
      S_FILL: begin
        if (memAck) begin
          if (idx_q == 2'd3) begin
            state_d = S_RESP;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
      end
    endcase

    line_sel_s = (state_d == S_WB) ? wb_line_d : fill_line_d;
    if ((state_d == S_WB) || (state_d == S_FILL)) begin
      mem_addr_d = {line_sel_s, idx_d, 2'b00};
    end else begin
      mem_addr_d = {ADDR_WIDTH{1'b0}};
    end
    if (state_d == S_WB) begin
      mem_wdata_d = wdata_d[int'(idx_d)*WORD_WIDTH +: WORD_WIDTH];
    end else begin
      mem_wdata_d = {WORD_WIDTH{1'b0}};
    end
  end

  // State, captured request, fill buffer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      is_read_q    <= 1'b0;
      dirty_q      <= 4'd0;
      fill_line_q  <= {LINE_W{1'b0}};
      wb_line_q    <= {LINE_W{1'b0}};
      wdata_q      <= {(4*WORD_WIDTH){1'b0}};
      buf_q        <= {(3*WORD_WIDTH){1'b0}};
      resp_data_q  <= {(4*WORD_WIDTH){1'b0}};
      resp_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q  <= {WORD_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      is_read_q    <= is_read_d;
      dirty_q      <= dirty_d;
      fill_line_q  <= fill_line_d;
      wb_line_q    <= wb_line_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= (state_d == S_RESP);
      mem_req_q    <= (state_d == S_WB) || (state_d == S_FILL);
      mem_we_q     <= (state_d == S_WB);
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      // Word 3 bypasses the buffer so the line is complete on the last beat.
      if ((state_q == S_FILL) && memAck) begin
        if (idx_q == 2'd3) begin
          resp_data_q <= {memReadData, buf_q[2], buf_q[1], buf_q[0]};
        end else begin
          buf_q[idx_q] <= memReadData;
        end
      end else begin
        resp_data_q <= resp_data_q;
      end
    end
  end

endmodule
